regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single write port of the 8x8-bit register file between two writers: execute (ex_) and load (ld_).
//  Each writer has a 1-entry holding buffer with a valid/ready handshake.
//  A round-robin arbiter drains one buffer per cycle into registered rf_we/rf_waddr/rf_wdata outputs.
//  Sits between the execute/load stages and the register file write port.
// PARAMETERS
//  DATA_W   8   register data width
//  ADDR_W   3   register index width (8 registers)
//  CNT_W    8   width of the saturating conflict counter
// PORTS
//  clk           in   1        system clock, all state on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  ex_valid      in   1        execute writer has a write request
//  ex_ready      out  1        execute buffer empty; a request is taken when ex_valid & ex_ready
//  ex_addr       in   ADDR_W   execute destination register
//  ex_data       in   DATA_W   execute write data
//  ld_valid      in   1        load writer has a write request
//  ld_ready      out  1        load buffer empty
//  ld_addr       in   ADDR_W   load destination register
//  ld_data       in   DATA_W   load write data
//  rf_we         out  1        register file write enable (registered)
//  rf_waddr      out  ADDR_W   register file write index (registered)
//  rf_wdata      out  DATA_W   register file write data (registered)
//  last_grant    out  1        0 = ex drained last, 1 = ld drained last
//  busy          out  1        at least one buffer is full
//  conflict_cnt  out  CNT_W    cycles in which both buffers were full (saturating)
// BEHAVIOUR
//  - Reset (async, immediate):
//      ex_full = ld_full = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0
//      last_grant = 1 (ex wins the first tie); conflict_cnt = 0
//      Buffered writes are discarded. No write reaches the regfile after rst_n falls.
//  - Ready signals: ex_ready = !ex_full and ld_ready = !ld_full (combinational from the full flags only).
//      A full buffer does not accept a request in its drain cycle. Ready rises the cycle after the drain.
//  - Capture: on a clock edge with valid & ready, the buffer stores addr/data and its full flag sets.
//  - Arbitration: evaluated each cycle from the full flags before the edge.
//      Only ex_full -> grant ex. Only ld_full -> grant ld.
//      Both full -> grant the writer != last_grant. Neither full -> no grant.
//  - Drain (at the edge):
//      Granted buffer clears. rf_waddr/rf_wdata load the buffer contents. rf_we = 1. last_grant updates.
//      No grant -> rf_we = 0; rf_waddr/rf_wdata hold their previous values.
//  - Latency: request accepted at edge k -> rf_we high in the cycle after edge k+1 (when it is the only full buffer).
//      Under contention, worst case is edge k+2.
//  - Throughput: one regfile write per cycle in aggregate. Each writer can issue at most one write every 2 cycles.
//  - Same address in both buffers: both writes are performed in grant order. The later grant's data persists.
//      There is no merging.
//  - Starvation-free: a full buffer waits at most 1 cycle behind the other.
//  - conflict_cnt increments on each edge where ex_full & ld_full, and saturates at 2^CNT_W-1.
//  - busy = ex_full | ld_full (combinational).
// CONFIGURATION
//  REGFILE_ARB_R0_DISCARD_EN defined:
//      Register 0 is the hardwired zero. A write with addr 0 is accepted and drained normally.
//      It consumes its arbitration slot and updates last_grant, but rf_we stays 0 for that cycle.
//  Macro undefined: addr 0 is written like any other register.
// TESTING
//  1 Reset: hold rst_n=0 with ex_valid=1 -> rf_we=0, conflict_cnt=0, ex/ld_ready=1. No capture until rst_n=1.
//  2 Single write: ex addr=3 data=8'hA5 -> rf_we=1, waddr=3, wdata=A5 for exactly 1 cycle, 2 edges after the
//    request; ex_ready low for 1 cycle.
//  3 Tie: ex(2,8'h11) and ld(2,8'h22) accepted on the same edge after reset -> ex written first, then ld.
//    Final r2=8'h22. conflict_cnt=1. last_grant=1.
//  4 Continuous contention, both writers always valid for 20 cycles -> strict ex/ld alternation and no
//    writer skipped. conflict_cnt increments on edges with both buffers full and saturates at 255 in a long run.
//  5 Reset mid-operation: both buffers full, rst_n pulsed low between edges -> rf_we drops immediately.
//    Neither pending write appears after release.
//  6 Macro on: ld addr=0 data=8'hFF -> buffer drains and last_grant=1, but rf_we stays 0.
//    Macro off -> rf_we=1, waddr=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single write port of an 8x8 register file
// between the execute (ex_) and load (ld_) writers. Each writer owns a
// 1-entry holding buffer with a valid/ready handshake. A round-robin arbiter
// drains one buffer per cycle into registered rf_we/rf_waddr/rf_wdata outputs.
//
// Optional build macro: REGFILE_ARB_R0_DISCARD_EN
//   When defined, register 0 is the hardwired zero: a write to address 0 is
//   accepted, drained and arbitrated normally, but rf_we stays low for it.

module regfile_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_grant,
  output logic              busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    SRC_EX = 1'b0,
    SRC_LD = 1'b1
  } src_e;

  // Buffer state
  logic              ex_full_q, ex_full_d;
  logic              ld_full_q, ld_full_d;
  logic [ADDR_W-1:0] ex_addr_q, ld_addr_q;
  logic [DATA_W-1:0] ex_data_q, ld_data_q;

  // Arbitration / output state
  src_e              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              grant_ex, grant_ld;
  logic              ex_take, ld_take;

  // Ready depends only on the full flags, so a buffer never refills in the
  // same cycle it drains.
  assign ex_ready = !ex_full_q;
  assign ld_ready = !ld_full_q;
  assign ex_take  = ex_valid && ex_ready;
  assign ld_take  = ld_valid && ld_ready;
  assign busy     = ex_full_q || ld_full_q;

  // Round-robin grant: on a tie the writer that did not drain last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    grant_ex = 1'b0;
    grant_ld = 1'b0;
    if (ex_full_q && ld_full_q) begin
      if (last_grant_q == SRC_LD) grant_ex = 1'b1;
      else                        grant_ld = 1'b1;
    end else begin
      grant_ex = ex_full_q;
      grant_ld = ld_full_q;
    end
  end

  // Next-state for full flags, write port, grant history and conflict counter.
  always_comb begin
    ex_full_d      = ex_full_q;
    ld_full_d      = ld_full_q;
    last_grant_d   = last_grant_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    conflict_cnt_d = conflict_cnt_q;

    if (ex_take)  ex_full_d = 1'b1;
    if (ld_take)  ld_full_d = 1'b1;

    if (grant_ex) begin
      ex_full_d    = 1'b0;
      last_grant_d = SRC_EX;
      rf_we_d      = 1'b1;
      rf_waddr_d   = ex_addr_q;
      rf_wdata_d   = ex_data_q;
    end else if (grant_ld) begin
      ld_full_d    = 1'b0;
      last_grant_d = SRC_LD;
      rf_we_d      = 1'b1;
      rf_waddr_d   = ld_addr_q;
      rf_wdata_d   = ld_data_q;
    end

`ifdef REGFILE_ARB_R0_DISCARD_EN
    // Register 0 reads as zero: the slot is used but nothing is written.
    if (rf_waddr_d == '0) rf_we_d = 1'b0;
`else
    // Address 0 is an ordinary register.
`endif

    if (ex_full_q && ld_full_q && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  // Control state: cleared immediately by reset so no buffered write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      ex_full_q      <= 1'b0;
      ld_full_q      <= 1'b0;
      last_grant_q   <= SRC_LD;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      ex_full_q      <= ex_full_d;
      ld_full_q      <= ld_full_d;
      last_grant_q   <= last_grant_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Buffer payload capture on an accepted handshake.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; their contents are only ever
    // used while the matching full flag (which is reset) is set.
    if (ex_take) begin
      ex_addr_q <= ex_addr;
      ex_data_q <= ex_data;
    end
    if (ld_take) begin
      ld_addr_q <= ld_addr;
      ld_data_q <= ld_data;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter. Accepted requests are pushed to
// an expected-write queue (ex before ld when both are taken on one edge) and
// popped when the DUT asserts rf_we. Directed checks cover reset, latency,
// tie-break, contention, counter saturation, mid-run reset and address 0.

module tb_regfile_wr_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0, ld_valid = 1'b0;
  logic [ADDR_W-1:0] ex_addr = '0, ld_addr = '0;
  logic [DATA_W-1:0] ex_data = '0, ld_data = '0;
  logic              ex_ready, ld_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              last_grant;
  logic              busy;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .last_grant(last_grant), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] obs_rf [8];
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_writes = 0;
  int                n_ex_wr, n_ld_wr;
  logic              prev_src;
  logic              have_prev;
  logic [CNT_W-1:0]  cnt0;
  int                writes0;
  logic              v;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
`ifdef REGFILE_ARB_R0_DISCARD_EN
    if (a == '0) return;
`endif
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic ev, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                      input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd);
    logic ex_acc, ld_acc;
    wr_t  got;
    ex_valid = ev; ex_addr = ea; ex_data = ed;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    #1;
    ex_acc = ev && ex_ready;
    ld_acc = lv && ld_ready;
    @(posedge clk);
    if (ex_acc) push_exp(ea, ed);
    if (ld_acc) push_exp(la, ldd);
    @(negedge clk);
    ex_valid = 1'b0;
    ld_valid = 1'b0;
    if (rf_we) begin
      n_writes++;
      obs_rf[rf_waddr] = rf_wdata;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_we", 32'(rf_we), 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("sb_write", 32'({rf_waddr, rf_wdata}), 32'(got));
      end
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Bounded drain of outstanding expected writes.
  task automatic drain(input string tag);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // 1: reset held with a request pending -> nothing captured
    ex_valid = 1'b1; ex_addr = 3'd1; ex_data = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd1);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    idle();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rf_we", 32'(rf_we), 32'd0);

    // 2: single ex write, visible after the second edge, for one cycle
    step(1'b1, 3'd3, 8'hA5, 1'b0, '0, '0);
    check("single_ex_ready_low", 32'(ex_ready), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_no_we_yet", 32'(rf_we), 32'd0);
    idle();
    check("single_we", 32'(rf_we), 32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd3);
    check("single_wdata", 32'(rf_wdata), 32'hA5);
    check("single_ex_ready_back", 32'(ex_ready), 32'd1);
    check("single_last_grant", 32'(last_grant), 32'd0);
    idle();
    check("single_we_one_cycle", 32'(rf_we), 32'd0);
    check("single_waddr_hold", 32'(rf_waddr), 32'd3);

    // 3: tie right after reset -> ex first, then ld
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    step(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22);
    check("tie_both_full", 32'({ex_ready, ld_ready}), 32'd0);
    check("tie_cnt_before", 32'(conflict_cnt), 32'd0);
    idle();
    check("tie_first_data", 32'(rf_wdata), 32'h11);
    check("tie_first_grant", 32'(last_grant), 32'd0);
    check("tie_cnt", 32'(conflict_cnt), 32'd1);
    idle();
    check("tie_second_data", 32'(rf_wdata), 32'h22);
    check("tie_last_grant", 32'(last_grant), 32'd1);
    check("tie_r2_final", 32'(obs_rf[2]), 32'h22);
    check("tie_cnt_final", 32'(conflict_cnt), 32'd1);

    // 4: continuous contention for 20 cycles -> strict alternation
    cnt0 = conflict_cnt;
    have_prev = 1'b0;
    n_ex_wr = 0;
    n_ld_wr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'(i % 8), 8'(8'h10 + i), 1'b1, 3'((i + 3) % 8), 8'(8'h80 + i));
      if (rf_we) begin
        if (rf_wdata[7]) n_ld_wr++; else n_ex_wr++;
        if (have_prev) check("contend_alternate", 32'(rf_wdata[7] != prev_src), 32'd1);
        prev_src  = rf_wdata[7];
        have_prev = 1'b1;
      end
    end
    drain("contend_drain");
    check("contend_ex_share", 32'(n_ex_wr >= 9), 32'd1);
    check("contend_ld_share", 32'(n_ld_wr >= 9), 32'd1);
    check("contend_cnt", 32'(conflict_cnt), 32'(cnt0 + 8'd1));

    // 5: reset between edges while ld is still pending -> write dropped
    step(1'b1, 3'd5, 8'h33, 1'b1, 3'd6, 8'h44);
    idle();
    check("midrst_pre_we", 32'(rf_we), 32'd1);
    check("midrst_pre_ld_full", 32'(ld_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we_drop", 32'(rf_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt", 32'(conflict_cnt), 32'd0);
    check("midrst_last_grant", 32'(last_grant), 32'd1);
    exp_q.delete();
    writes0 = n_writes;
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (3) idle();
    check("midrst_no_stale_write", 32'(n_writes), 32'(writes0));

    // 4b: repeated ties from empty -> counter climbs then saturates
    for (int s = 0; s < 900; s++) begin
      v = ex_ready && ld_ready;
      step(v, 3'(s % 8), 8'(s), v, 3'((s + 1) % 8), ~8'(s));
      if (s == 29)  check("sat_cnt_10", 32'(conflict_cnt), 32'd10);
      if (s == 760) check("sat_cnt_254", 32'(conflict_cnt), 32'd254);
    end
    check("sat_cnt_255", 32'(conflict_cnt), 32'd255);
    drain("sat_drain");
    check("sat_cnt_hold", 32'(conflict_cnt), 32'd255);

    // 6: ld write to address 0
    step(1'b1, 3'd4, 8'h5A, 1'b0, '0, '0);
    idle();
    check("r0_pre_grant", 32'(last_grant), 32'd0);
    step(1'b0, '0, '0, 1'b1, 3'd0, 8'hFF);
    idle();
`ifdef REGFILE_ARB_R0_DISCARD_EN
    check("r0_discard_we", 32'(rf_we), 32'd0);
`else
    check("r0_we", 32'(rf_we), 32'd1);
    check("r0_waddr", 32'(rf_waddr), 32'd0);
    check("r0_wdata", 32'(rf_wdata), 32'hFF);
`endif
    check("r0_last_grant", 32'(last_grant), 32'd1);
    check("r0_ld_ready", 32'(ld_ready), 32'd1);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
